// File: rtl/full_adder_if.sv
// rtl/full_adder_if.sv - operand/result bundle for the registered ripple-carry adder
// Optional ovf signal exists only when FULL_ADDER_OVF_EN is defined.
interface full_adder_if #(
  parameter int WIDTH = 1
);

  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             out_valid;
`ifdef FULL_ADDER_OVF_EN
  logic             ovf;

  modport master (
    output in_valid, a, b, cin,
    input  sum, cout, out_valid, ovf
  );

  modport slave (
    input  in_valid, a, b, cin,
    output sum, cout, out_valid, ovf
  );
`else
  modport master (
    output in_valid, a, b, cin,
    input  sum, cout, out_valid
  );

  modport slave (
    input  in_valid, a, b, cin,
    output sum, cout, out_valid
  );
`endif

endinterface

// File: rtl/full_adder.sv
// rtl/full_adder.sv - registered WIDTH-bit ripple-carry adder, {cout,sum} = a + b + cin
// Optional signed-overflow output is enabled by defining FULL_ADDER_OVF_EN.
// WIDTH is legal over 1..64; the interface instance must use the same WIDTH.
module full_adder #(
  parameter int WIDTH = 1
) (
  input  logic        clk,
  input  logic        rst,
  full_adder_if.slave bus
);

  // Ripple chain: w_c[i] is the carry into cell i, w_c[WIDTH] is the MSB carry-out.
  logic [WIDTH:0]   w_c;
  logic [WIDTH-1:0] w_s;

  assign w_c[0] = bus.cin;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
    assign w_s[gi]     = bus.a[gi] ^ bus.b[gi] ^ w_c[gi];
    assign w_c[gi + 1] = (bus.a[gi] & bus.b[gi]) |
                         (bus.a[gi] & w_c[gi])   |
                         (bus.b[gi] & w_c[gi]);
  end

  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_out_valid;

  // Capture the chain result only on accepted inputs so idle (possibly X) operands never reach the outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_sum  <= w_s;
        r_cout <= w_c[WIDTH];
      end
    end
  end

  assign bus.sum       = r_sum;
  assign bus.cout      = r_cout;
  assign bus.out_valid = r_out_valid;

`ifdef FULL_ADDER_OVF_EN
  // Signed overflow is carry-into-MSB xor carry-out-of-MSB; for WIDTH=1 the carry into the MSB is cin.
  logic w_ovf;
  logic r_ovf;

  assign w_ovf = w_c[WIDTH] ^ w_c[WIDTH-1];

  // Overflow flag is registered alongside sum and holds while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (bus.in_valid) begin
      r_ovf <= w_ovf;
    end
  end

  assign bus.ovf = r_ovf;
`endif

endmodule

// File: tb/tb_full_adder.sv
// tb/tb_full_adder.sv - directed-vector bench for full_adder at WIDTH=1 and WIDTH=8
// Overflow checks compile in only when FULL_ADDER_OVF_EN is defined.
module tb_full_adder;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;

  full_adder_if #(.WIDTH(1)) if1 ();
  full_adder_if #(.WIDTH(8)) if8 ();

  full_adder #(.WIDTH(1)) u_fa1 (
    .clk (clk),
    .rst (rst),
    .bus (if1)
  );

  full_adder #(.WIDTH(8)) u_fa8 (
    .clk (clk),
    .rst (rst),
    .bus (if8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst          = 1'b1;
    if1.in_valid = 1'b1;
    if1.a        = 1'b1;
    if1.b        = 1'b1;
    if1.cin      = 1'b1;
    if8.in_valid = 1'b1;
    if8.a        = 8'hFF;
    if8.b        = 8'hFF;
    if8.cin      = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      n_total++;
      if (if1.sum !== 1'b0) $display("FAIL reset_sum1 cycle %0d got %b exp 0", k, if1.sum);
      else n_pass++;
      n_total++;
      if (if1.cout !== 1'b0) $display("FAIL reset_cout1 cycle %0d got %b exp 0", k, if1.cout);
      else n_pass++;
      n_total++;
      if (if1.out_valid !== 1'b0) $display("FAIL reset_valid1 cycle %0d got %b exp 0", k, if1.out_valid);
      else n_pass++;
      n_total++;
      if (if8.sum !== 8'h00) $display("FAIL reset_sum8 cycle %0d got %h exp 00", k, if8.sum);
      else n_pass++;
      n_total++;
      if (if8.out_valid !== 1'b0) $display("FAIL reset_valid8 cycle %0d got %b exp 0", k, if8.out_valid);
      else n_pass++;
`ifdef FULL_ADDER_OVF_EN
      n_total++;
      if (if8.ovf !== 1'b0) $display("FAIL reset_ovf8 cycle %0d got %b exp 0", k, if8.ovf);
      else n_pass++;
`endif
    end
    rst          = 1'b0;
    if1.in_valid = 1'b0;
    if8.in_valid = 1'b0;
    tick();
    n_total++;
    if (if1.sum !== 1'b0 || if1.cout !== 1'b0)
      $display("FAIL post_reset_result1 got sum=%b cout=%b exp sum=0 cout=0", if1.sum, if1.cout);
    else n_pass++;
    n_total++;
    if (if1.out_valid !== 1'b0) $display("FAIL post_reset_valid1 got %b exp 0", if1.out_valid);
    else n_pass++;
    n_total++;
    if (if8.out_valid !== 1'b0) $display("FAIL post_reset_valid8 got %b exp 0", if8.out_valid);
    else n_pass++;
  endtask

  task automatic test_truth_table();
    // Index = {a,b,cin}; entry = {sum,cout}.
    logic [1:0] exp_sc [8];
    logic [2:0] abc;
    exp_sc = '{2'b00, 2'b10, 2'b10, 2'b01, 2'b10, 2'b01, 2'b01, 2'b11};
    for (int i = 0; i < 8; i++) begin
      abc          = 3'(i);
      if1.in_valid = 1'b1;
      if1.a        = abc[2];
      if1.b        = abc[1];
      if1.cin      = abc[0];
      tick();
      n_total++;
      if ({if1.sum, if1.cout} !== exp_sc[i] || if1.out_valid !== 1'b1)
        $display("FAIL truth_table abc=%b got sum=%b cout=%b valid=%b exp sum=%b cout=%b valid=1",
                 abc, if1.sum, if1.cout, if1.out_valid, exp_sc[i][1], exp_sc[i][0]);
      else n_pass++;
    end
    if1.in_valid = 1'b0;
    tick();
    n_total++;
    if (if1.out_valid !== 1'b0 || if1.sum !== 1'b1 || if1.cout !== 1'b1)
      $display("FAIL truth_table_idle got valid=%b sum=%b cout=%b exp valid=0 sum=1 cout=1",
               if1.out_valid, if1.sum, if1.cout);
    else n_pass++;
  endtask

  task automatic test_w8_vectors();
    logic [7:0] va [5];
    logic [7:0] vb [5];
    logic       vc [5];
    logic [7:0] es [5];
    logic       ec [5];
    va = '{8'hFF, 8'hFF, 8'h00, 8'h12, 8'hA5};
    vb = '{8'h01, 8'hFF, 8'h00, 8'h34, 8'h5A};
    vc = '{1'b0,  1'b1,  1'b0,  1'b1,  1'b1 };
    es = '{8'h00, 8'hFF, 8'h00, 8'h47, 8'h00};
    ec = '{1'b1,  1'b1,  1'b0,  1'b0,  1'b1 };
    for (int i = 0; i < 5; i++) begin
      if8.in_valid = 1'b1;
      if8.a        = va[i];
      if8.b        = vb[i];
      if8.cin      = vc[i];
      tick();
      n_total++;
      if (if8.sum !== es[i] || if8.cout !== ec[i] || if8.out_valid !== 1'b1)
        $display("FAIL w8_vector %0d got sum=%h cout=%b valid=%b exp sum=%h cout=%b valid=1",
                 i, if8.sum, if8.cout, if8.out_valid, es[i], ec[i]);
      else n_pass++;
    end
    if8.in_valid = 1'b0;
    tick();
  endtask

  task automatic test_hold();
    if8.in_valid = 1'b1;
    if8.a        = 8'h12;
    if8.b        = 8'h05;
    if8.cin      = 1'b1;
    tick();
    n_total++;
    if (if8.out_valid !== 1'b1 || if8.sum !== 8'h18 || if8.cout !== 1'b0)
      $display("FAIL hold_first got valid=%b sum=%h cout=%b exp valid=1 sum=18 cout=0",
               if8.out_valid, if8.sum, if8.cout);
    else n_pass++;
    if8.in_valid = 1'b0;
    if8.a        = 'x;
    if8.b        = 'x;
    if8.cin      = 1'bx;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_total++;
      if (if8.out_valid !== 1'b0 || if8.sum !== 8'h18 || if8.cout !== 1'b0)
        $display("FAIL hold_idle cycle %0d got valid=%b sum=%h cout=%b exp valid=0 sum=18 cout=0",
                 k, if8.out_valid, if8.sum, if8.cout);
      else n_pass++;
    end
  endtask

  task automatic test_reset_midstream();
    if8.in_valid = 1'b1;
    if8.a        = 8'h40;
    if8.b        = 8'h40;
    if8.cin      = 1'b0;
    tick();
    n_total++;
    if (if8.out_valid !== 1'b1 || if8.sum !== 8'h80)
      $display("FAIL midstream_first got valid=%b sum=%h exp valid=1 sum=80", if8.out_valid, if8.sum);
    else n_pass++;
    // Input presented together with reset must be discarded.
    if8.a        = 8'h01;
    if8.b        = 8'h01;
    rst          = 1'b1;
    tick();
    n_total++;
    if (if8.out_valid !== 1'b0 || if8.sum !== 8'h00 || if8.cout !== 1'b0)
      $display("FAIL midstream_reset got valid=%b sum=%h cout=%b exp valid=0 sum=00 cout=0",
               if8.out_valid, if8.sum, if8.cout);
    else n_pass++;
    rst          = 1'b0;
    if8.in_valid = 1'b0;
    tick();
    n_total++;
    if (if8.out_valid !== 1'b0 || if8.sum !== 8'h00)
      $display("FAIL midstream_after got valid=%b sum=%h exp valid=0 sum=00", if8.out_valid, if8.sum);
    else n_pass++;
  endtask

`ifdef FULL_ADDER_OVF_EN
  task automatic test_ovf();
    logic [7:0] va [3];
    logic [7:0] vb [3];
    logic [7:0] es [3];
    logic       ec [3];
    logic       eo [3];
    va = '{8'h7F, 8'h80, 8'h01};
    vb = '{8'h01, 8'hFF, 8'h01};
    es = '{8'h80, 8'h7F, 8'h02};
    ec = '{1'b0,  1'b1,  1'b0 };
    eo = '{1'b1,  1'b1,  1'b0 };
    for (int i = 0; i < 3; i++) begin
      if8.in_valid = 1'b1;
      if8.a        = va[i];
      if8.b        = vb[i];
      if8.cin      = 1'b0;
      tick();
      n_total++;
      if (if8.ovf !== eo[i] || if8.sum !== es[i] || if8.cout !== ec[i])
        $display("FAIL ovf_vector %0d got ovf=%b sum=%h cout=%b exp ovf=%b sum=%h cout=%b",
                 i, if8.ovf, if8.sum, if8.cout, eo[i], es[i], ec[i]);
      else n_pass++;
    end
    if8.in_valid = 1'b1;
    if8.a        = 8'h7F;
    if8.b        = 8'h01;
    tick();
    if8.in_valid = 1'b0;
    if8.a        = 8'h01;
    tick();
    n_total++;
    if (if8.ovf !== 1'b1) $display("FAIL ovf_hold got %b exp 1", if8.ovf);
    else n_pass++;
  endtask
`endif

  initial begin
    n_pass       = 0;
    n_total      = 0;
    rst          = 1'b1;
    if1.in_valid = 1'b0;
    if1.a        = '0;
    if1.b        = '0;
    if1.cin      = 1'b0;
    if8.in_valid = 1'b0;
    if8.a        = '0;
    if8.b        = '0;
    if8.cin      = 1'b0;
    test_reset();
    test_truth_table();
    test_w8_vectors();
    test_hold();
    test_reset_midstream();
`ifdef FULL_ADDER_OVF_EN
    test_ovf();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
